vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
- Transaction engine on the input side of the vending-machine display path.
- Accepts debounced coin pulses and product-select pulses. Maintains the running balance and the selected product's cost, and drives both to the display block.
- Issues the vend pulse when funds suffice, then pays out change one coin per cycle.
- Single clock domain. All inputs are already synchronised and debounced upstream.

Parameters:
- PRICE_0, 15, cost of product select bit 0
- PRICE_1, 20, cost of product select bit 1
- PRICE_2, 25, cost of product select bit 2
- PRICE_3, 30, cost of product select bit 3
- MAX_BAL, 95, balance ceiling; must be a multiple of 5 and ≤ 255
- VEND_HOLD, 4, cycles the vend output is held high (≥ 1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- coin  input  3  one-cycle one-hot coin pulse: 001 = 5, 010 = 10, 100 = 25
- product  input  4  one-cycle one-hot product request; bit i selects PRICE_i
- cancel  input  1  one-cycle pulse requesting refund of the balance
- balance  output  8  current credit, binary
- cost  output  8  cost of the last valid request, binary; 0 when none
- vend  output  4  one-hot dispense strobe, held VEND_HOLD cycles
- change_coin  output  3  one-hot returned-coin pulse, same encoding as coin
- reject  output  1  one-cycle pulse: inserted coin not accepted (physically returned)
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; balance = 0; cost = 0; vend = 0; change_coin = 0; reject = 0; busy = 0.
  - Reset mid-VEND or mid-CHANGE aborts immediately. Unreturned credit is lost.
- All outputs are registered; every response appears in the cycle after the stimulus edge.
- Coin decode:
  - Exactly one bit set means a valid coin.
  - coin = 000 is no event.
  - Any other multi-hot value is invalid and produces reject.
- Product decode: anything other than exactly one bit set is ignored (no state change).
- FSM states: IDLE, VEND, CHANGE.
- IDLE, priority order within a single cycle:
  1. cancel = 1:
     - balance > 0: go to CHANGE.
     - balance = 0: cost <= 0, stay in IDLE.
     - Any coin in the same cycle is rejected; product is ignored.
  2. Valid product:
     - cost <= PRICE_i.
     - If balance ≥ PRICE_i: balance <= balance − PRICE_i, vend <= the one-hot product value, go to VEND.
     - Otherwise stay in IDLE with balance unchanged (display shows the shortfall context).
     - Any coin in the same cycle is rejected; the comparison uses the pre-coin balance.
  3. Valid coin:
     - If balance + value ≤ MAX_BAL: balance <= balance + value.
     - Otherwise reject and leave balance unchanged (no saturation).
- VEND:
  - vend is held VEND_HOLD cycles via a down-counter.
  - On expiry: vend <= 0. If balance > 0, go to CHANGE. Otherwise go to IDLE with cost <= 0.
- CHANGE:
  - Each cycle, pay out the largest coin ≤ balance: 25, then 10, then 5.
  - change_coin pulses for one cycle with that coin's one-hot code, and balance decreases by that value in the same update.
  - Back-to-back pulses are allowed.
  - When the updated balance is 0: go to IDLE, cost <= 0, change_coin <= 0 the following cycle.
- In VEND and CHANGE:
  - Every valid or invalid nonzero coin produces reject.
  - product and cancel are ignored.
- Width and arithmetic:
  - Balance arithmetic is 8-bit unsigned. Overflow is impossible because of the MAX_BAL guard.
  - Balance is always a multiple of 5, so CHANGE always terminates at exactly 0.
- reject is a single-cycle pulse per offending coin cycle. It never asserts without a nonzero coin input that cycle.
- busy = (state != IDLE), registered with the state.

Test Plan:
1. Reset release, then coins 25, 10, 5 on separate cycles → balance 25, 35, 40; reject stays 0; cost 0.
2. balance 40, product = 0010 → cost 20; balance 20; vend = 0010 for exactly 4 cycles; then change_coin = 010, 010 on consecutive cycles; balance 0; state IDLE; cost 0.
3. balance 10, product = 1000 → cost 30; balance stays 10; vend stays 0; busy stays 0. Then cancel → one change_coin = 010 pulse; balance 0; cost 0.
4. balance 90, coin = 100 → reject pulse; balance 90. Then coin = 001 → balance 95. Then coin = 011 → reject; balance 95.
5. Same cycle: balance 30, product = 0100 and coin = 010 → reject; cost 25; balance 5; VEND for 4 cycles; then change_coin = 001; balance 0.
6. Assert reset low during the CHANGE phase with balance 35 → all outputs 0 asynchronously, before the next clock edge. After release, a coin 5 gives balance 5.

Source files
------------

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Brief    : Vending transaction engine. Tracks credit and selected cost,
//            issues the vend strobe and pays out change one coin per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int PRICE_0   = 15,
    parameter int PRICE_1   = 20,
    parameter int PRICE_2   = 25,
    parameter int PRICE_3   = 30,
    parameter int MAX_BAL   = 95,
    parameter int VEND_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] coin,
    input  logic [3:0] product,
    input  logic       cancel,
    output logic [7:0] balance,
    output logic [7:0] cost,
    output logic [3:0] vend,
    output logic [2:0] change_coin,
    output logic       reject,
    output logic       busy
);

    localparam int c_cnt_w = (VEND_HOLD > 1) ? $clog2(VEND_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_balance;
    logic [7:0]         w_balance_nxt;
    logic [7:0]         r_cost;
    logic [7:0]         w_cost_nxt;
    logic [3:0]         r_vend;
    logic [3:0]         w_vend_nxt;
    logic [2:0]         r_change;
    logic [2:0]         w_change_nxt;
    logic               r_reject;
    logic               w_reject_nxt;
    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    logic               w_coin_valid;
    logic               w_coin_any;
    logic [7:0]         w_coin_val;
    logic               w_prod_valid;
    logic [7:0]         w_price;
    logic [8:0]         w_sum;
    logic [7:0]         w_pay_val;
    logic [2:0]         w_pay_code;

    assign w_coin_valid = $onehot(coin);
    assign w_coin_any   = |coin;
    assign w_prod_valid = $onehot(product);
    assign w_sum        = {1'b0, r_balance} + {1'b0, w_coin_val};

    always_comb begin
        w_coin_val = 8'd0;
        case (coin)
            3'b001:  w_coin_val = 8'd5;
            3'b010:  w_coin_val = 8'd10;
            3'b100:  w_coin_val = 8'd25;
            default: w_coin_val = 8'd0;
        endcase
    end

    always_comb begin
        w_price = 8'd0;
        case (product)
            4'b0001: w_price = 8'(PRICE_0);
            4'b0010: w_price = 8'(PRICE_1);
            4'b0100: w_price = 8'(PRICE_2);
            4'b1000: w_price = 8'(PRICE_3);
            default: w_price = 8'd0;
        endcase
    end

    // Greedy payout; balance is always a multiple of 5 so this ends at zero.
    always_comb begin
        if (r_balance >= 8'd25) begin
            w_pay_val  = 8'd25;
            w_pay_code = 3'b100;
        end else if (r_balance >= 8'd10) begin
            w_pay_val  = 8'd10;
            w_pay_code = 3'b010;
        end else begin
            w_pay_val  = 8'd5;
            w_pay_code = 3'b001;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_balance_nxt = r_balance;
        w_cost_nxt    = r_cost;
        w_vend_nxt    = r_vend;
        w_change_nxt  = 3'b000;
        w_reject_nxt  = 1'b0;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    w_reject_nxt = w_coin_any;
                    if (r_balance != 8'd0) begin
                        w_state_nxt = S_CHANGE;
                    end else begin
                        w_cost_nxt = 8'd0;
                    end
                end else if (w_prod_valid) begin
                    w_reject_nxt = w_coin_any;
                    w_cost_nxt   = w_price;
                    if (r_balance >= w_price) begin
                        w_balance_nxt = r_balance - w_price;
                        w_vend_nxt    = product;
                        w_cnt_nxt     = c_cnt_w'(VEND_HOLD - 1);
                        w_state_nxt   = S_VEND;
                    end
                end else if (w_coin_valid) begin
                    if (w_sum <= 9'(MAX_BAL)) begin
                        w_balance_nxt = w_sum[7:0];
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else begin
                    w_reject_nxt = w_coin_any;
                end
            end

            S_VEND: begin
                w_reject_nxt = w_coin_any;
                if (r_cnt == '0) begin
                    w_vend_nxt = 4'b0000;
                    if (r_balance != 8'd0) begin
                        w_state_nxt = S_CHANGE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cost_nxt  = 8'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            S_CHANGE: begin
                w_reject_nxt = w_coin_any;
                if (r_balance == 8'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cost_nxt  = 8'd0;
                end else begin
                    w_balance_nxt = r_balance - w_pay_val;
                    w_change_nxt  = w_pay_code;
                    if (r_balance == w_pay_val) begin
                        w_state_nxt = S_IDLE;
                        w_cost_nxt  = 8'd0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_balance <= 8'd0;
            r_cost    <= 8'd0;
            r_vend    <= 4'b0000;
            r_change  <= 3'b000;
            r_reject  <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_balance <= w_balance_nxt;
            r_cost    <= w_cost_nxt;
            r_vend    <= w_vend_nxt;
            r_change  <= w_change_nxt;
            r_reject  <= w_reject_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign balance     = r_balance;
    assign cost        = r_cost;
    assign vend        = r_vend;
    assign change_coin = r_change;
    assign reject      = r_reject;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Brief    : Scoreboard bench for vend_controller against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    localparam int c_hold = 4;
    localparam int c_max  = 95;

    typedef struct packed {
        logic [7:0] bal;
        logic [7:0] cost;
        logic [3:0] vend;
        logic [2:0] chg;
        logic       rej;
        logic       busy;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] coin;
    logic [3:0] product;
    logic       cancel;
    logic [7:0] balance;
    logic [7:0] cost;
    logic [3:0] vend;
    logic [2:0] change_coin;
    logic       reject;
    logic       busy;

    snap_t q[$];
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    tmo_cnt  = 0;
    int    tmo_seen = 0;
    int    m_bal    = 0;
    int    m_cost   = 0;
    int    prices[4] = '{15, 20, 25, 30};

    vend_controller #(
        .PRICE_0(15), .PRICE_1(20), .PRICE_2(25), .PRICE_3(30),
        .MAX_BAL(c_max), .VEND_HOLD(c_hold)
    ) dut (
        .clk(clk), .reset(reset), .coin(coin), .product(product),
        .cancel(cancel), .balance(balance), .cost(cost), .vend(vend),
        .change_coin(change_coin), .reject(reject), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: while reset is low every output must be zero; otherwise each
    // cycle with an expectation queued is compared against it.
    initial begin
        snap_t g;
        snap_t e;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            g = {balance, cost, vend, change_coin, reject, busy};
            if (tmo_cnt != tmo_seen) begin
                tmo_seen = tmo_cnt;
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout: expectations still queued after cycle budget");
            end
            if (!reset) begin
                n_tests++;
                if (g !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs got bal=%0d cost=%0d vend=%b chg=%b rej=%b busy=%b, want all zero",
                             balance, cost, vend, change_coin, reject, busy);
                end
            end else if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL trace t=%0t got bal=%0d cost=%0d vend=%b chg=%b rej=%b busy=%b want bal=%0d cost=%0d vend=%b chg=%b rej=%b busy=%b",
                             $time, balance, cost, vend, change_coin, reject, busy,
                             e.bal, e.cost, e.vend, e.chg, e.rej, e.busy);
                end
            end
        end
    end

    task automatic push(input int b, input int c, input logic [3:0] v,
                        input logic [2:0] ch, input logic rj, input logic bs);
        snap_t s;
        s.bal  = 8'(b);
        s.cost = 8'(c);
        s.vend = v;
        s.chg  = ch;
        s.rej  = rj;
        s.busy = bs;
        q.push_back(s);
    endtask

    function automatic int coin_value(input logic [2:0] cn);
        case (cn)
            3'b001:  return 5;
            3'b010:  return 10;
            3'b100:  return 25;
            default: return 0;
        endcase
    endfunction

    task automatic pay_change();
        int          c;
        logic [2:0]  code;
        while (m_bal > 0) begin
            if (m_bal >= 25) begin c = 25; code = 3'b100; end
            else if (m_bal >= 10) begin c = 10; code = 3'b010; end
            else begin c = 5; code = 3'b001; end
            m_bal -= c;
            if (m_bal == 0) m_cost = 0;
            push(m_bal, m_cost, 4'b0, code, 1'b0, m_bal != 0);
        end
    endtask

    // One transaction: drive for one cycle, queue the full expected response
    // plus one quiet cycle, then wait for the monitor to consume it.
    task automatic do_op(input logic [2:0] cn, input logic [3:0] pr, input logic cl);
        logic rj;
        int   p;
        @(negedge clk);
        coin = cn; product = pr; cancel = cl;
        rj = (cn != 3'b0);
        if (cl) begin
            if (m_bal > 0) begin
                push(m_bal, m_cost, 4'b0, 3'b0, rj, 1'b1);
                pay_change();
            end else begin
                m_cost = 0;
                push(m_bal, 0, 4'b0, 3'b0, rj, 1'b0);
            end
        end else if ($countones(pr) == 1) begin
            p = 0;
            for (int i = 0; i < 4; i++) if (pr[i]) p = prices[i];
            m_cost = p;
            if (m_bal >= p) begin
                m_bal -= p;
                for (int i = 0; i < c_hold; i++)
                    push(m_bal, m_cost, pr, 3'b0, (i == 0) ? rj : 1'b0, 1'b1);
                if (m_bal > 0) begin
                    push(m_bal, m_cost, 4'b0, 3'b0, 1'b0, 1'b1);
                    pay_change();
                end else begin
                    m_cost = 0;
                    push(0, 0, 4'b0, 3'b0, 1'b0, 1'b0);
                end
            end else begin
                push(m_bal, m_cost, 4'b0, 3'b0, rj, 1'b0);
            end
        end else begin
            if ($countones(cn) == 1 && m_bal + coin_value(cn) <= c_max) begin
                m_bal += coin_value(cn);
                rj = 1'b0;
            end
            push(m_bal, m_cost, 4'b0, 3'b0, rj, 1'b0);
        end
        push(m_bal, m_cost, 4'b0, 3'b0, 1'b0, 1'b0);
        @(negedge clk);
        coin = 3'b0; product = 4'b0; cancel = 1'b0;
        for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            q.delete();
            tmo_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] valid_coins[3] = '{3'b001, 3'b010, 3'b100};
        logic [2:0] bad_coins[4]   = '{3'b011, 3'b101, 3'b110, 3'b111};
        logic [3:0] bad_prods[4]   = '{4'b0000, 4'b0101, 4'b1100, 4'b1111};
        logic [2:0] cn;
        logic [3:0] pr;
        int         r;

        reset = 1'b0; coin = 3'b0; product = 4'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b010, 4'b0, 1'b0);
        do_op(3'b001, 4'b0, 1'b0);
        do_op(3'b000, 4'b0010, 1'b0);
        do_op(3'b010, 4'b0, 1'b0);
        do_op(3'b000, 4'b1000, 1'b0);
        do_op(3'b000, 4'b0, 1'b1);
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b010, 4'b0, 1'b0);
        do_op(3'b001, 4'b0, 1'b0);
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b001, 4'b0, 1'b0);
        do_op(3'b011, 4'b0, 1'b0);
        do_op(3'b000, 4'b0, 1'b1);
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b001, 4'b0, 1'b0);
        do_op(3'b010, 4'b0100, 1'b0);

        // Abort mid-payout: build 35, cancel, reset after the first 25 coin.
        do_op(3'b100, 4'b0, 1'b0);
        do_op(3'b010, 4'b0, 1'b0);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_bal = 0;
        m_cost = 0;
        do_op(3'b001, 4'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 11));
            cn = valid_coins[$urandom_range(0, 2)];
            pr = 4'b0001 << $urandom_range(0, 3);
            if (r <= 6)       do_op(cn, 4'b0, 1'b0);
            else if (r == 7)  do_op(bad_coins[$urandom_range(0, 3)], 4'b0, 1'b0);
            else if (r <= 9)  do_op(($urandom_range(0, 3) == 0) ? cn : 3'b0, pr, 1'b0);
            else if (r == 10) do_op(($urandom_range(0, 2) == 0) ? cn : 3'b0, 4'b0, 1'b1);
            else              do_op(cn, bad_prods[$urandom_range(0, 3)], 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
